// File: rtl/lsu_pkg.sv
// Shared types, reset constants and op-decode helpers for the memory-stage LSU.
package lsu_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned STRB_W = XLEN / 8;

    // Values driven on every register while in reset.
    localparam logic              RST_VALID = 1'b0;
    localparam logic [XLEN-1:0]   RST_DATA  = '0;
    localparam logic [REG_AW-1:0] RST_REG   = '0;
    localparam logic [STRB_W-1:0] RST_STRB  = '0;

    typedef enum logic [OP_W-1:0] {
        LSU_NONE  = 4'd0,
        LSU_LD_B  = 4'd1,
        LSU_LD_H  = 4'd2,
        LSU_LD_W  = 4'd3,
        LSU_LD_BU = 4'd4,
        LSU_LD_HU = 4'd5,
        LSU_ST_B  = 4'd6,
        LSU_ST_H  = 4'd7,
        LSU_ST_W  = 4'd8
    } lsu_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } lsu_state_t;

    function automatic logic is_load(lsu_op_t op);
        return (op == LSU_LD_B) || (op == LSU_LD_H) || (op == LSU_LD_W) ||
               (op == LSU_LD_BU) || (op == LSU_LD_HU);
    endfunction

    function automatic logic is_store(lsu_op_t op);
        return (op == LSU_ST_B) || (op == LSU_ST_H) || (op == LSU_ST_W);
    endfunction

    // Halfwords need an even address, words need a 4-byte aligned address.
    function automatic logic is_misaligned(lsu_op_t op, logic [1:0] lo);
        logic half_op;
        logic word_op;
        half_op = (op == LSU_LD_H) || (op == LSU_LD_HU) || (op == LSU_ST_H);
        word_op = (op == LSU_LD_W) || (op == LSU_ST_W);
        return (half_op && lo[0]) || (word_op && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Load lane extract/extend and store strobe/lane replication, keyed by op and addr[1:0].
module lsu_align
    import lsu_pkg::*;
(
    input  lsu_op_t           op_i,
    input  logic [1:0]        addr_lo_i,
    input  logic [XLEN-1:0]   st_data_i,
    input  logic [XLEN-1:0]   ld_word_i,
    output logic [STRB_W-1:0] wstrb_o,
    output logic [XLEN-1:0]   wdata_o,
    output logic [XLEN-1:0]   ld_data_o
);

    // Select the addressed lane and shape it for the op.
    always_comb begin
        logic [7:0]  lane_b;
        logic [15:0] lane_h;

        wstrb_o   = RST_STRB;
        wdata_o   = RST_DATA;
        ld_data_o = RST_DATA;
        lane_b    = ld_word_i[{addr_lo_i, 3'b000} +: 8];
        lane_h    = addr_lo_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];

        case (op_i)
            LSU_LD_B:  ld_data_o = {{24{lane_b[7]}}, lane_b};
            LSU_LD_BU: ld_data_o = {24'd0, lane_b};
            LSU_LD_H:  ld_data_o = {{16{lane_h[15]}}, lane_h};
            LSU_LD_HU: ld_data_o = {16'd0, lane_h};
            LSU_LD_W:  ld_data_o = ld_word_i;
            LSU_ST_B: begin
                wstrb_o = 4'b0001 << addr_lo_i;
                wdata_o = {4{st_data_i[7:0]}};
            end
            LSU_ST_H: begin
                wstrb_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{st_data_i[15:0]}};
            end
            LSU_ST_W: begin
                wstrb_o = 4'b1111;
                wdata_o = st_data_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage LSU: runs the dmem valid/ready transaction and emits one writeback record per entry.
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              in_valid,
    output logic              in_ready,
    output logic              stall_req,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_inst,
    input  logic [DATA_W-1:0] in_ex_result,
    input  logic              in_rw_en,
    input  logic [4:0]        in_rw_addr,
    input  logic [DATA_W-1:0] in_lsu_data,
    input  logic [3:0]        in_lsu_op,

    output logic              dmem_req_valid,
    input  logic              dmem_req_ready,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic              dmem_we,
    output logic [3:0]        dmem_wstrb,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_resp_valid,
    input  logic [DATA_W-1:0] dmem_resp_rdata,

    output logic              out_valid,
    output logic [DATA_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_inst,
    output logic [DATA_W-1:0] out_result,
    output logic              out_rw_en,
    output logic [4:0]        out_rw_addr,
    output logic              out_misalign
);

    lsu_state_t        state_q;
    lsu_op_t           op_q;
    logic [1:0]        addr_lo_q;
    logic [DATA_W-1:0] pc_q;
    logic [DATA_W-1:0] inst_q;
    logic              rw_en_q;
    logic [4:0]        rw_addr_q;

    logic              req_valid_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic              req_we_q;
    logic [3:0]        req_wstrb_q;
    logic [DATA_W-1:0] req_wdata_q;

    logic              wb_valid_q;
    logic [DATA_W-1:0] wb_pc_q;
    logic [DATA_W-1:0] wb_inst_q;
    logic [DATA_W-1:0] wb_result_q;
    logic              wb_rw_en_q;
    logic [4:0]        wb_rw_addr_q;
    logic              wb_misalign_q;

    lsu_op_t           in_op;
    logic              in_is_mem;
    logic              in_misal;
    lsu_op_t           al_op;
    logic [1:0]        al_lo;
    logic [3:0]        al_wstrb;
    logic [DATA_W-1:0] al_wdata;
    logic [DATA_W-1:0] al_ld_data;

    assign in_op     = lsu_op_t'(in_lsu_op);
    assign in_is_mem = is_load(in_op) || is_store(in_op);
    assign in_misal  = is_misaligned(in_op, in_ex_result[1:0]);

    // One aligner serves both directions: store shaping from the incoming entry while idle,
    // load extraction from the latched op/offset once a transaction is in flight.
    assign al_op = (state_q == S_IDLE) ? in_op : op_q;
    assign al_lo = (state_q == S_IDLE) ? in_ex_result[1:0] : addr_lo_q;

    lsu_align u_align (
        .op_i      (al_op),
        .addr_lo_i (al_lo),
        .st_data_i (in_lsu_data),
        .ld_word_i (dmem_resp_rdata),
        .wstrb_o   (al_wstrb),
        .wdata_o   (al_wdata),
        .ld_data_o (al_ld_data)
    );

    // Transaction FSM with registered dmem request and writeback record.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            op_q          <= LSU_NONE;
            addr_lo_q     <= 2'b00;
            pc_q          <= RST_DATA;
            inst_q        <= RST_DATA;
            rw_en_q       <= RST_VALID;
            rw_addr_q     <= RST_REG;
            req_valid_q   <= RST_VALID;
            req_addr_q    <= '0;
            req_we_q      <= RST_VALID;
            req_wstrb_q   <= RST_STRB;
            req_wdata_q   <= RST_DATA;
            wb_valid_q    <= RST_VALID;
            wb_pc_q       <= RST_DATA;
            wb_inst_q     <= RST_DATA;
            wb_result_q   <= RST_DATA;
            wb_rw_en_q    <= RST_VALID;
            wb_rw_addr_q  <= RST_REG;
            wb_misalign_q <= RST_VALID;
        end else begin
            wb_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        if (!in_is_mem || in_misal) begin
                            // Single-cycle record: ALU passthrough or alignment fault.
                            wb_valid_q    <= 1'b1;
                            wb_pc_q       <= in_pc;
                            wb_inst_q     <= in_inst;
                            wb_result_q   <= in_ex_result;
                            wb_rw_en_q    <= in_rw_en && !in_is_mem;
                            wb_rw_addr_q  <= in_rw_addr;
                            wb_misalign_q <= in_is_mem;
                        end else begin
                            op_q        <= in_op;
                            addr_lo_q   <= in_ex_result[1:0];
                            pc_q        <= in_pc;
                            inst_q      <= in_inst;
                            rw_en_q     <= in_rw_en;
                            rw_addr_q   <= in_rw_addr;
                            req_valid_q <= 1'b1;
                            req_addr_q  <= ADDR_W'({in_ex_result[DATA_W-1:2], 2'b00});
                            req_we_q    <= is_store(in_op);
                            req_wstrb_q <= al_wstrb;
                            req_wdata_q <= al_wdata;
                            state_q     <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (dmem_req_ready) begin
                        req_valid_q <= 1'b0;
                        if (is_store(op_q)) begin
                            // Stores retire on the handshake and write back nothing.
                            wb_valid_q    <= 1'b1;
                            wb_pc_q       <= pc_q;
                            wb_inst_q     <= inst_q;
                            wb_result_q   <= RST_DATA;
                            wb_rw_en_q    <= 1'b0;
                            wb_rw_addr_q  <= rw_addr_q;
                            wb_misalign_q <= 1'b0;
                            state_q       <= S_IDLE;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (dmem_resp_valid) begin
                        wb_valid_q    <= 1'b1;
                        wb_pc_q       <= pc_q;
                        wb_inst_q     <= inst_q;
                        wb_result_q   <= al_ld_data;
                        wb_rw_en_q    <= rw_en_q;
                        wb_rw_addr_q  <= rw_addr_q;
                        wb_misalign_q <= 1'b0;
                        state_q       <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready       = (state_q == S_IDLE);
    assign stall_req      = !in_ready;

    assign dmem_req_valid = req_valid_q;
    assign dmem_addr      = req_addr_q;
    assign dmem_we        = req_we_q;
    assign dmem_wstrb     = req_wstrb_q;
    assign dmem_wdata     = req_wdata_q;

    assign out_valid      = wb_valid_q;
    assign out_pc         = wb_pc_q;
    assign out_inst       = wb_inst_q;
    assign out_result     = wb_result_q;
    assign out_rw_en      = wb_rw_en_q;
    assign out_rw_addr    = wb_rw_addr_q;
    assign out_misalign   = wb_misalign_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed scenarios plus a randomized run against a byte-level memory model.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        stall_req;
    logic [31:0] in_pc, in_inst, in_ex_result, in_lsu_data;
    logic        in_rw_en;
    logic [4:0]  in_rw_addr;
    logic [3:0]  in_lsu_op;
    logic        dmem_req_valid, dmem_req_ready, dmem_we, dmem_resp_valid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_resp_rdata;
    logic [3:0]  dmem_wstrb;
    logic        out_valid, out_rw_en, out_misalign;
    logic [31:0] out_pc, out_inst, out_result;
    logic [4:0]  out_rw_addr;

    always #5 clk = ~clk;

    mem_stage_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .stall_req(stall_req),
        .in_pc(in_pc), .in_inst(in_inst), .in_ex_result(in_ex_result),
        .in_rw_en(in_rw_en), .in_rw_addr(in_rw_addr),
        .in_lsu_data(in_lsu_data), .in_lsu_op(in_lsu_op),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_wstrb(dmem_wstrb),
        .dmem_wdata(dmem_wdata), .dmem_resp_valid(dmem_resp_valid),
        .dmem_resp_rdata(dmem_resp_rdata),
        .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
        .out_result(out_result), .out_rw_en(out_rw_en),
        .out_rw_addr(out_rw_addr), .out_misalign(out_misalign)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int req_seen = 0;

    typedef struct {
        int          cyc;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] result;
        logic        rw_en;
        logic [4:0]  rw_addr;
        logic        misal;
    } rec_t;

    rec_t oq[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Collect every writeback pulse with the cycle it was seen in.
    always @(negedge clk) begin
        if (out_valid)
            oq.push_back('{cyc, out_pc, out_inst, out_result, out_rw_en, out_rw_addr, out_misalign});
        if (dmem_req_valid)
            req_seen <= req_seen + 1;
    end

    // Data memory: word-organised slave; the model below is byte-organised.
    logic [31:0] smem [64];
    logic [7:0]  mbytes [256];
    int rdy_wait = 0, rsp_wait = 0;
    bit spur_en = 1'b0;
    int rdy_cnt = 0, rsp_cnt = 0, rsp_idx = 0;
    bit rsp_pend = 1'b0;

    initial begin
        dmem_req_ready  = 1'b0;
        dmem_resp_valid = 1'b0;
        dmem_resp_rdata = '0;
        forever begin
            @(negedge clk);
            dmem_req_ready  = 1'b0;
            dmem_resp_valid = 1'b0;
            if (rsp_pend) begin
                if (rsp_cnt >= rsp_wait) begin
                    dmem_resp_valid = 1'b1;
                    dmem_resp_rdata = smem[rsp_idx];
                    rsp_pend = 1'b0;
                end else begin
                    rsp_cnt++;
                end
            end else if (dmem_req_valid) begin
                if (rdy_cnt >= rdy_wait) begin
                    dmem_req_ready = 1'b1;
                    rdy_cnt = 0;
                    if (dmem_we) begin
                        for (int k = 0; k < 4; k++)
                            if (dmem_wstrb[k]) smem[dmem_addr[7:2]][8*k +: 8] = dmem_wdata[8*k +: 8];
                    end else begin
                        rsp_pend = 1'b1;
                        rsp_cnt  = 0;
                        rsp_idx  = int'(dmem_addr[7:2]);
                    end
                end else begin
                    rdy_cnt++;
                end
            end else if (spur_en && $urandom_range(0, 3) == 0) begin
                dmem_resp_valid = 1'b1;
                dmem_resp_rdata = $urandom;
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic int size_of(int op);
        case (op)
            1, 4, 6: return 1;
            2, 5, 7: return 2;
            3, 8:    return 4;
            default: return 0;
        endcase
    endfunction

    function automatic bit m_misal(int op, logic [31:0] a);
        int sz = size_of(op);
        return (sz > 1) && ((a % sz) != 0);
    endfunction

    function automatic logic [31:0] m_load(int op, logic [31:0] a);
        longint v = 0;
        int sz = size_of(op);
        for (int k = 0; k < sz; k++)
            v = v | (longint'(mbytes[(a + k) & 255]) << (8 * k));
        if ((op == 1 || op == 2) && v[8*sz-1])
            v = v - (longint'(1) << (8 * sz));
        return v[31:0];
    endfunction

    task automatic m_store(input int op, input logic [31:0] a, input logic [31:0] d);
        for (int k = 0; k < size_of(op); k++)
            mbytes[(a + k) & 255] = 8'(d >> (8 * k));
    endtask

    task automatic set_word(input int idx, input logic [31:0] w);
        smem[idx] = w;
        for (int k = 0; k < 4; k++) mbytes[idx*4 + k] = 8'(w >> (8 * k));
    endtask

    // ---------------- drivers ----------------
    task automatic issue(input int op, input logic [31:0] ex, input logic [31:0] dat,
                         input logic rwen, input logic [4:0] rwa, input logic [31:0] pc,
                         output int acc);
        @(negedge clk);
        in_valid = 1'b1; in_lsu_op = 4'(op); in_ex_result = ex; in_lsu_data = dat;
        in_rw_en = rwen; in_rw_addr = rwa; in_pc = pc; in_inst = ~pc;
        for (int i = 0; i < 60 && !in_ready; i++) @(negedge clk);
        if (!in_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL issue_timeout in_ready=%0b required=1 pc=%h", in_ready, pc);
        end
        acc = cyc + 1;
    endtask

    task automatic idle_in();
        @(negedge clk);
        in_valid = 1'b0; in_lsu_op = 4'd0;
    endtask

    task automatic drain(input int n, input int budget);
        for (int i = 0; i < budget && oq.size() < n; i++) @(negedge clk);
        repeat (3) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({out_valid, out_rw_en, out_misalign, dmem_req_valid, dmem_we} !== 5'b0) begin
            n_bad++; $display("FAIL reset_flags got=%b required=00000",
                              {out_valid, out_rw_en, out_misalign, dmem_req_valid, dmem_we});
        end
        n_cmp++;
        if ({in_ready, stall_req} !== 2'b10) begin
            n_bad++; $display("FAIL reset_ready got=%b required=10", {in_ready, stall_req});
        end
        n_cmp++;
        if ({out_result, out_pc, dmem_addr, dmem_wdata} !== 128'd0) begin
            n_bad++; $display("FAIL reset_data got=%h required=0", {out_result, out_pc, dmem_addr, dmem_wdata});
        end
        n_cmp++;
        if ({dmem_wstrb, out_rw_addr} !== 9'd0) begin
            n_bad++; $display("FAIL reset_strb_rd got=%h required=0", {dmem_wstrb, out_rw_addr});
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_alu();
        int acc, r0;
        oq.delete();
        r0 = req_seen;
        issue(0, 32'h1234, 32'h0, 1'b1, 5'd5, 32'h40, acc);
        idle_in();
        drain(1, 10);
        n_cmp++;
        if (oq.size() != 1) begin n_bad++; $display("FAIL alu_count got=%0d required=1", oq.size()); end
        n_cmp++;
        if (oq[0].cyc != acc) begin n_bad++; $display("FAIL alu_latency got=%0d required=%0d", oq[0].cyc, acc); end
        n_cmp++;
        if (oq[0].result !== 32'h1234) begin n_bad++; $display("FAIL alu_result got=%h required=00001234", oq[0].result); end
        n_cmp++;
        if ({oq[0].rw_en, oq[0].rw_addr, oq[0].misal} !== {1'b1, 5'd5, 1'b0}) begin
            n_bad++; $display("FAIL alu_rw got=%b/%0d/%b required=1/5/0", oq[0].rw_en, oq[0].rw_addr, oq[0].misal);
        end
        n_cmp++;
        if (req_seen != r0) begin n_bad++; $display("FAIL alu_no_req got=%0d required=%0d", req_seen, r0); end
    endtask

    task automatic test_load_byte();
        int acc;
        logic [31:0] exp_v [2];
        int ops [2];
        ops[0] = 1; ops[1] = 4;
        exp_v[0] = 32'hFFFF_FF80; exp_v[1] = 32'h0000_0080;
        rdy_wait = 0; rsp_wait = 0;
        set_word(0, 32'h80FF_FF7F);
        for (int t = 0; t < 2; t++) begin
            oq.delete();
            issue(ops[t], 32'h1003, 32'h0, 1'b1, 5'd7, 32'h80 + 32'(t), acc);
            idle_in();
            n_cmp++;
            if ({dmem_req_valid, dmem_we, dmem_addr} !== {1'b1, 1'b0, 32'h1000}) begin
                n_bad++; $display("FAIL ldb_req got=%b/%b/%h required=1/0/00001000", dmem_req_valid, dmem_we, dmem_addr);
            end
            drain(1, 20);
            n_cmp++;
            if (oq[0].cyc != acc + 2) begin n_bad++; $display("FAIL ldb_latency got=%0d required=%0d", oq[0].cyc, acc + 2); end
            n_cmp++;
            if (oq[0].result !== exp_v[t] || oq[0].result !== m_load(ops[t], 32'h1003)) begin
                n_bad++; $display("FAIL ldb_result op=%0d got=%h required=%h", ops[t], oq[0].result, exp_v[t]);
            end
        end
    endtask

    task automatic test_store_half();
        int acc, nreq, last_req, out_c;
        rdy_wait = 3;
        nreq = 0; last_req = -1; out_c = -1;
        oq.delete();
        issue(7, 32'h2002, 32'hABCD_1234, 1'b1, 5'd9, 32'hC0, acc);
        idle_in();
        for (int i = 0; i < 20; i++) begin
            if (dmem_req_valid) begin
                nreq++; last_req = cyc;
                n_cmp++;
                if ({dmem_addr, dmem_we, dmem_wstrb, dmem_wdata, stall_req} !==
                    {32'h2000, 1'b1, 4'b1100, 32'h1234_1234, 1'b1}) begin
                    n_bad++; $display("FAIL sth_req_stable got=%h/%b/%b/%h/%b required=00002000/1/1100/12341234/1",
                                      dmem_addr, dmem_we, dmem_wstrb, dmem_wdata, stall_req);
                end
            end
            if (out_valid) begin out_c = cyc; break; end
            @(negedge clk);
        end
        n_cmp++;
        if (nreq != 4) begin n_bad++; $display("FAIL sth_req_cycles got=%0d required=4", nreq); end
        n_cmp++;
        if (out_c != last_req + 1) begin n_bad++; $display("FAIL sth_out_timing got=%0d required=%0d", out_c, last_req + 1); end
        n_cmp++;
        if ({out_rw_en, out_misalign, stall_req} !== 3'b000) begin
            n_bad++; $display("FAIL sth_out_flags got=%b required=000", {out_rw_en, out_misalign, stall_req});
        end
        m_store(7, 32'h2002, 32'hABCD_1234);
        rdy_wait = 0;
        idle_in();
        oq.delete();
        issue(3, 32'h2000, 32'h0, 1'b1, 5'd10, 32'hC4, acc);
        idle_in();
        drain(1, 20);
        n_cmp++;
        if (oq[0].result !== m_load(3, 32'h2000)) begin
            n_bad++; $display("FAIL sth_readback got=%h required=%h", oq[0].result, m_load(3, 32'h2000));
        end
    endtask

    task automatic test_misaligned();
        int ops [5];
        logic [31:0] adr [5];
        int acc [5];
        int r0;
        ops = '{3, 2, 5, 7, 8};
        adr = '{32'h1002, 32'h1001, 32'h1003, 32'h1005, 32'h1006};
        oq.delete();
        r0 = req_seen;
        for (int i = 0; i < 5; i++) issue(ops[i], adr[i], 32'h5555_AAAA, 1'b1, 5'(i + 1), 32'h200 + 32'(4*i), acc[i]);
        idle_in();
        drain(5, 20);
        n_cmp++;
        if (oq.size() != 5) begin n_bad++; $display("FAIL mis_count got=%0d required=5", oq.size()); end
        for (int i = 0; i < 5 && i < oq.size(); i++) begin
            n_cmp++;
            if ({oq[i].misal, oq[i].rw_en} !== 2'b10) begin
                n_bad++; $display("FAIL mis_flags idx=%0d got=%b required=10", i, {oq[i].misal, oq[i].rw_en});
            end
            n_cmp++;
            if (oq[i].cyc != acc[0] + i || acc[i] != acc[0] + i) begin
                n_bad++; $display("FAIL mis_throughput idx=%0d got=%0d required=%0d", i, oq[i].cyc, acc[0] + i);
            end
        end
        n_cmp++;
        if (req_seen != r0) begin n_bad++; $display("FAIL mis_no_req got=%0d required=%0d", req_seen, r0); end
    endtask

    task automatic test_reset_in_wait();
        int acc;
        rdy_wait = 0; rsp_wait = 1;
        oq.delete();
        issue(3, 32'h1004, 32'h0, 1'b1, 5'd3, 32'h300, acc);
        idle_in();
        @(negedge clk);
        n_cmp++;
        if (stall_req !== 1'b1) begin n_bad++; $display("FAIL rstw_in_wait got=%b required=1", stall_req); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({out_valid, in_ready, stall_req, dmem_req_valid, out_rw_en} !== 5'b01000) begin
            n_bad++; $display("FAIL rstw_flags got=%b required=01000",
                              {out_valid, in_ready, stall_req, dmem_req_valid, out_rw_en});
        end
        n_cmp++;
        if ({out_result, dmem_addr} !== 64'd0) begin
            n_bad++; $display("FAIL rstw_data got=%h required=0", {out_result, dmem_addr});
        end
        rst = 1'b1;
        drain(1, 4);
        n_cmp++;
        if (oq.size() != 0 || in_ready !== 1'b1) begin
            n_bad++; $display("FAIL rstw_resp_ignored got=%0d/%b required=0/1", oq.size(), in_ready);
        end
        rsp_wait = 0;
    endtask

    task automatic test_interleave();
        int a0, a1, a2;
        rdy_wait = 0; rsp_wait = 2;
        oq.delete();
        issue(0, 32'hCAFE_0001, 32'h0, 1'b1, 5'd1, 32'h400, a0);
        issue(5, 32'h1006, 32'h0, 1'b1, 5'd2, 32'h404, a1);
        issue(0, 32'hCAFE_0003, 32'h0, 1'b1, 5'd3, 32'h408, a2);
        idle_in();
        drain(3, 40);
        n_cmp++;
        if (oq.size() != 3) begin n_bad++; $display("FAIL ilv_count got=%0d required=3", oq.size()); end
        n_cmp++;
        if ({oq[0].rw_addr, oq[1].rw_addr, oq[2].rw_addr} !== {5'd1, 5'd2, 5'd3}) begin
            n_bad++; $display("FAIL ilv_order got=%0d,%0d,%0d required=1,2,3", oq[0].rw_addr, oq[1].rw_addr, oq[2].rw_addr);
        end
        n_cmp++;
        if ({oq[0].result, oq[1].result, oq[2].result} !== {32'hCAFE_0001, m_load(5, 32'h1006), 32'hCAFE_0003}) begin
            n_bad++; $display("FAIL ilv_results got=%h,%h,%h required=cafe0001,%h,cafe0003",
                              oq[0].result, oq[1].result, oq[2].result, m_load(5, 32'h1006));
        end
        n_cmp++;
        if (oq[1].cyc != a1 + 4 || oq[2].cyc != oq[1].cyc + 1 || a1 != a0 + 1) begin
            n_bad++; $display("FAIL ilv_timing got=%0d/%0d required=%0d/%0d", oq[1].cyc, oq[2].cyc, a1 + 4, a1 + 5);
        end
        rsp_wait = 0;
    endtask

    task automatic test_random();
        rec_t exp[$];
        bit chk_res[$];
        int n = 200;
        int acc;
        oq.delete();
        spur_en = 1'b1;
        for (int i = 0; i < n; i++) begin
            int op, sz;
            logic [31:0] a, d, ex, pc;
            logic rwen;
            logic [4:0] rwa;
            rec_t e;
            op = $urandom_range(0, 8);
            sz = size_of(op);
            a = 32'h1000 + 32'($urandom_range(0, 255));
            if (sz > 0 && $urandom_range(0, 2) != 0) a = a & ~32'(sz - 1);
            d = $urandom; rwen = 1'($urandom); rwa = 5'($urandom);
            pc = 32'h8000 + 32'(4 * i);
            ex = (op == 0) ? $urandom : a;
            e.cyc = 0; e.pc = pc; e.inst = ~pc; e.rw_addr = rwa;
            e.misal = 1'b0; e.result = ex; e.rw_en = rwen;
            if (op == 0) begin
                chk_res.push_back(1'b1);
            end else if (m_misal(op, a)) begin
                e.misal = 1'b1; e.rw_en = 1'b0; chk_res.push_back(1'b0);
            end else if (op >= 6) begin
                m_store(op, a, d); e.rw_en = 1'b0; chk_res.push_back(1'b0);
            end else begin
                e.result = m_load(op, a); chk_res.push_back(1'b1);
            end
            exp.push_back(e);
            rdy_wait = $urandom_range(0, 2);
            rsp_wait = $urandom_range(0, 2);
            issue(op, ex, d, rwen, rwa, pc, acc);
        end
        idle_in();
        spur_en = 1'b0;
        drain(n, 3000);
        n_cmp++;
        if (oq.size() != n) begin n_bad++; $display("FAIL rnd_count got=%0d required=%0d", oq.size(), n); end
        for (int i = 0; i < n && i < oq.size(); i++) begin
            n_cmp++;
            if ({oq[i].pc, oq[i].inst, oq[i].rw_en, oq[i].misal} !== {exp[i].pc, exp[i].inst, exp[i].rw_en, exp[i].misal}) begin
                n_bad++; $display("FAIL rnd_rec idx=%0d got=%h/%h/%b/%b required=%h/%h/%b/%b", i,
                                  oq[i].pc, oq[i].inst, oq[i].rw_en, oq[i].misal,
                                  exp[i].pc, exp[i].inst, exp[i].rw_en, exp[i].misal);
            end
            if (chk_res[i]) begin
                n_cmp++;
                if ({oq[i].result, oq[i].rw_addr} !== {exp[i].result, exp[i].rw_addr}) begin
                    n_bad++; $display("FAIL rnd_result idx=%0d got=%h/%0d required=%h/%0d", i,
                                      oq[i].result, oq[i].rw_addr, exp[i].result, exp[i].rw_addr);
                end
            end
        end
        rdy_wait = 0; rsp_wait = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        in_valid = 1'b0; in_pc = '0; in_inst = '0; in_ex_result = '0; in_lsu_data = '0;
        in_rw_en = 1'b0; in_rw_addr = '0; in_lsu_op = '0;
        for (int i = 0; i < 64; i++) set_word(i, $urandom);
        test_reset();
        test_alu();
        test_load_byte();
        test_store_half();
        test_misaligned();
        test_reset_in_wait();
        test_interleave();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Memory-stage load/store unit that sits on the output side of the EX/MEM pipeline register. It consumes the registered EX result, which is either an ALU result or an effective address, together with store data and `lsu_op`. For memory ops it runs a valid/ready transaction on the data-memory port, aligns and extends load data, and presents one registered writeback record per instruction to MEM/WB. While a memory transaction is in flight it back-pressures the pipeline.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width (only 32 supported)

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset; one clock, reset is synchronous and active-low
- `in_valid`  in  1  EX/MEM entry valid
- `in_ready`  out  1  unit accepts an entry this cycle
- `stall_req`  out  1  equals `!in_ready`; freezes IF..EX/MEM
- `in_pc`, `in_inst`  in  32  passthrough
- `in_ex_result`  in  32  ALU result or effective address
- `in_rw_en`  in  1  register write enable
- `in_rw_addr`  in  5  destination register
- `in_lsu_data`  in  32  store data
- `in_lsu_op`  in  4  `lsu_op_t`
- `dmem_req_valid`  out  1  request valid
- `dmem_req_ready`  in  1  request accepted
- `dmem_addr`  out  32  word-aligned address (`{addr[31:2],2'b00}`)
- `dmem_we`  out  1  1 = store
- `dmem_wstrb`  out  4  byte strobes
- `dmem_wdata`  out  32  lane-replicated store data
- `dmem_resp_valid`  in  1  load data valid
- `dmem_resp_rdata`  in  32  load word
- `out_valid`  out  1  one-cycle writeback pulse
- `out_pc`, `out_inst`, `out_result`  out  32  writeback record
- `out_rw_en`  out  1  write enable
- `out_rw_addr`  out  5  destination register
- `out_misalign`  out  1  alignment exception flag for this record

## Operation
- The FSM has three states: IDLE, REQ, WAIT. `in_ready` = (state == IDLE).
- **IDLE, `in_valid`, `lsu_op` == NONE.** Register the passthrough fields, with `out_result` = `ex_result`. Pulse `out_valid` and stay in IDLE.
- **IDLE, memory op, misaligned.** Misaligned means H/HU with `addr[0]`=1, or W with `addr[1:0]`≠0. Issue no request. Pulse `out_valid` with `out_misalign`=1 and `out_rw_en` forced to 0. Stay in IDLE.
- **IDLE, memory op, aligned.** Latch pc, inst, addr, data, op, rw_en and rw_addr, then go to REQ.
- **REQ.** `dmem_req_valid`=1, and every `dmem_*` field is held stable until `dmem_req_ready`.
  - Store handshake: pulse `out_valid` with `out_rw_en`=0, then go to IDLE.
  - Load handshake: go to WAIT.
- **WAIT.** On `dmem_resp_valid`, extract the lane selected by `addr[1:0]`:
  - B/H: sign-extend.
  - BU/HU: zero-extend.
  - W: whole word.
  - Then pulse `out_valid` with the extended value and go to IDLE.
- **Store strobes and data:**
  - B: `wstrb` = `4'b0001 << addr[1:0]`, `wdata` = `{4{data[7:0]}}`.
  - H: `wstrb` = `0011` or `1100`, `wdata` = `{2{data[15:0]}}`.
  - W: `wstrb` = `1111`.
- `dmem_resp_valid` outside WAIT is ignored.
- MEM/WB never back-pressures.

## Timing
- Reset (`rst`=0 at a clock edge): state IDLE and every output 0, except that `in_ready`=1 and `stall_req`=0 follow from IDLE.
- Reset mid-transaction aborts the transaction. `dmem_req_valid` drops the next cycle, and a late response is ignored.
- All `out_*` signals are registered. `out_valid` is high for exactly one cycle per accepted entry.
- Non-memory and misaligned entries: accepted at edge N, `out_valid` high in cycle N+1, back-to-back throughput of 1 per cycle.
- Load, best case: accepted at edge 0; REQ in cycle 1 with ready=1; WAIT in cycle 2 with resp=1; `out_valid` in cycle 3. `stall_req` is high in cycles 1–2.
- Store, best case: `out_valid` in cycle 2.
- The earliest response is the cycle after the request handshake; a response in the same cycle as the handshake is illegal.

## Structure
- Shared package `lsu_pkg`:
  - `lsu_op_t` (4-bit): NONE=0, LD_B, LD_H, LD_W, LD_BU, LD_HU, ST_B, ST_H, ST_W.
  - Helpers `is_load` and `is_store`.
  - FSM state enum.
  - Reuse the existing `RST_VALID`-style constants from the constant include for invalid values.
- Sub-module `lsu_align`: combinational load extract/extend and store strobe/replicate, keyed by op and `addr[1:0]`.

## Test plan
- ALU op, `ex_result`=`0x1234`, `rw_addr`=5 → next cycle `out_valid`=1, `out_result`=`0x1234`; `dmem_req_valid` never asserted.
- LD_B at addr `0x1003`, memory word `0x80FF_FF7F`, ready and resp immediate → `dmem_addr`=`0x1000`, `out_result`=`0xFFFF_FF80`. LD_BU of the same → `0x0000_0080`.
- ST_H at addr `0x2002`, data `0xABCD_1234`, ready held 0 for 3 cycles → request fields stable throughout, `wstrb`=`1100`, `wdata`=`0x1234_1234`. `out_valid` with `rw_en`=0 one cycle after the handshake; `stall_req` high for the whole wait.
- LD_W at addr `0x1002` → no request, `out_misalign`=1, `out_rw_en`=0, one-cycle latency.
- Reset asserted while in WAIT, response arrives the next cycle → outputs 0, FSM IDLE, response ignored, no `out_valid`.
- Interleave ALU, LD_HU, ALU with a 2-cycle response delay → three `out_valid` pulses in program order; the second ALU op is held until the load completes.
